// File: rtl/rounder_flags_pipe.sv
// Two-stage normalisation-exception pipeline: leading-zero count in stage 1,
// exponent range flags (TINY/OVF1) in stage 2, with sticky accumulation on handshake.
module rounder_flags_pipe #(
  parameter int FW     = 57,
  parameter int EW     = 13,
  parameter int LZW    = 6,
  parameter int EMAX_D = 1023,
  parameter int EMIN_D = -1022,
  parameter int EMAX_S = 127,
  parameter int EMIN_S = -126
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [FW-1:0]        fr,
  input  logic signed [EW-1:0] er,
  input  logic                 db,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [LZW-1:0]       lz,
  output logic                 zero,
  output logic                 TINY,
  output logic                 OVF1,
  input  logic                 flag_clr,
  output logic                 sticky_tiny,
  output logic                 sticky_ovf
);

  localparam logic signed [EW:0] EMAX_D_E = (EW+1)'(EMAX_D);
  localparam logic signed [EW:0] EMIN_D_E = (EW+1)'(EMIN_D);
  localparam logic signed [EW:0] EMAX_S_E = (EW+1)'(EMAX_S);
  localparam logic signed [EW:0] EMIN_S_E = (EW+1)'(EMIN_S);

  // All-zero input falls through the loop and reports FW.
  function automatic logic [LZW-1:0] lzc(input logic [FW-1:0] v);
    logic [LZW-1:0] n;
    logic           found;
    n     = LZW'(FW);
    found = 1'b0;
    for (int i = FW - 1; i >= 0; i--) begin
      if (!found && v[i]) begin
        n     = LZW'(FW - 1 - i);
        found = 1'b1;
      end
    end
    return n;
  endfunction

  logic                 s1_valid_q, s1_valid_d;
  logic                 s2_valid_q, s2_valid_d;
  logic [LZW-1:0]       lz_p1_q, lz_p1_d;
  logic                 zero_p1_q, zero_p1_d;
  logic signed [EW-1:0] er_p1_q, er_p1_d;
  logic                 db_p1_q, db_p1_d;
  logic [LZW-1:0]       lz_p2_q, lz_p2_d;
  logic                 zero_p2_q, zero_p2_d;
  logic                 tiny_p2_q, tiny_p2_d;
  logic                 ovf_p2_q, ovf_p2_d;
  logic                 sticky_tiny_q, sticky_tiny_d;
  logic                 sticky_ovf_q, sticky_ovf_d;

  logic                 s2_free, s1_adv, accept, hs;
  logic signed [EW:0]   en_p1, emin_p1, emax_p1;

  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready;
    hs       = s2_valid_q && out_ready;

    s1_valid_d = accept || (s1_valid_q && !s2_free);
    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;

    // Stage 0 -> 1: leading-zero count and operand capture
    lz_p1_d   = lz_p1_q;
    zero_p1_d = zero_p1_q;
    er_p1_d   = er_p1_q;
    db_p1_d   = db_p1_q;
    if (accept) begin
      lz_p1_d   = lzc(fr);
      zero_p1_d = (fr == '0);
      er_p1_d   = er;
      db_p1_d   = db;
    end

    // Stage 1 -> 2: normalised exponent one bit wider than er, so it cannot overflow
    en_p1   = $signed({er_p1_q[EW-1], er_p1_q}) - $signed({{(EW+1-LZW){1'b0}}, lz_p1_q});
    emin_p1 = db_p1_q ? EMIN_D_E : EMIN_S_E;
    emax_p1 = db_p1_q ? EMAX_D_E : EMAX_S_E;

    lz_p2_d   = lz_p2_q;
    zero_p2_d = zero_p2_q;
    tiny_p2_d = tiny_p2_q;
    ovf_p2_d  = ovf_p2_q;
    if (s1_adv) begin
      lz_p2_d   = lz_p1_q;
      zero_p2_d = zero_p1_q;
      tiny_p2_d = !zero_p1_q && (en_p1 < emin_p1);
      ovf_p2_d  = !zero_p1_q && (en_p1 > emax_p1);
    end

    // A flag delivered in the same cycle as a clear still sets the sticky bit.
    sticky_tiny_d = (flag_clr ? 1'b0 : sticky_tiny_q) | (hs & tiny_p2_q);
    sticky_ovf_d  = (flag_clr ? 1'b0 : sticky_ovf_q)  | (hs & ovf_p2_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      s2_valid_q    <= 1'b0;
      lz_p2_q       <= '0;
      zero_p2_q     <= 1'b0;
      tiny_p2_q     <= 1'b0;
      ovf_p2_q      <= 1'b0;
      sticky_tiny_q <= 1'b0;
      sticky_ovf_q  <= 1'b0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      s2_valid_q    <= s2_valid_d;
      lz_p2_q       <= lz_p2_d;
      zero_p2_q     <= zero_p2_d;
      tiny_p2_q     <= tiny_p2_d;
      ovf_p2_q      <= ovf_p2_d;
      sticky_tiny_q <= sticky_tiny_d;
      sticky_ovf_q  <= sticky_ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    lz_p1_q   <= lz_p1_d;
    zero_p1_q <= zero_p1_d;
    er_p1_q   <= er_p1_d;
    db_p1_q   <= db_p1_d;
  end

  assign out_valid   = s2_valid_q;
  assign lz          = lz_p2_q;
  assign zero        = zero_p2_q;
  assign TINY        = tiny_p2_q;
  assign OVF1        = ovf_p2_q;
  assign sticky_tiny = sticky_tiny_q;
  assign sticky_ovf  = sticky_ovf_q;

endmodule

// File: doc/rounder_flags_pipe.md
ROUNDER_FLAGS_PIPE -- requirements
Module: rounder_flags_pipe

Interface
REQ-001 Parameter FW, default 57, fraction width of fr.
REQ-002 Parameter EW, default 13, exponent width of er (two's complement).
REQ-003 Parameter LZW, default 6, width of lz; SHALL satisfy 2**LZW > FW.
REQ-004 Parameters EMAX_D/EMIN_D, defaults 1023/-1022, double-precision exponent limits.
REQ-005 Parameters EMAX_S/EMIN_S, defaults 127/-126, single-precision exponent limits.
REQ-006 clk  input  1  single clock, all state rising-edge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 in_valid  input  1  operand valid.
REQ-009 in_ready  output  1  block accepts operand.
REQ-010 fr  input  FW  unnormalised fraction, MSB = integer position.
REQ-011 er  input  EW  signed exponent of fr[FW-1].
REQ-012 db  input  1  1 = double limits, 0 = single limits.
REQ-013 out_valid  output  1  result valid.
REQ-014 out_ready  input  1  consumer accepts result.
REQ-015 lz  output  LZW  leading-zero count of fr.
REQ-016 zero  output  1  fr was all zeros.
REQ-017 TINY  output  1  normalised exponent below minimum.
REQ-018 OVF1  output  1  normalised exponent above maximum.
REQ-019 flag_clr  input  1  synchronous clear of sticky flags.
REQ-020 sticky_tiny, sticky_ovf  output  1 each  accumulated exception flags.

Function
REQ-021 Accept on in_valid && in_ready; deliver on out_valid && out_ready.
REQ-022 Two-stage pipeline: stage 1 registers lz, zero, er, db; stage 2 registers TINY, OVF1 and passes lz, zero.
REQ-023 Latency exactly 2 cycles from accept to out_valid with no backpressure; throughput 1 per cycle.
REQ-024 Stage 1 advances when stage 2 empty or stage 2 advancing; stage 2 advances when out_ready.
REQ-025 in_ready = !s1_valid || s1 advancing (combinational, no dependence on in_valid).
REQ-026 While out_valid && !out_ready, all outputs SHALL hold stable; no transaction lost, duplicated or reordered.
REQ-027 lz = number of leading zeros of fr; fr == 0 gives lz = FW and zero = 1.
REQ-028 en = sign-extended er minus lz, computed at EW+1 bits, no overflow.
REQ-029 TINY = !zero && (en < EMIN), EMIN selected by db.
REQ-030 OVF1 = !zero && (en > EMAX), EMAX selected by db; TINY and OVF1 never both 1.
REQ-031 On each output handshake, sticky_tiny |= TINY and sticky_ovf |= OVF1.
REQ-032 flag_clr clears both sticky flags next edge; simultaneous handshake with set flag wins (sticky = 1).
REQ-033 Sticky flags unaffected by stalls; update only on handshake.

Reset
REQ-034 rst_n low asynchronously clears s1_valid, s2_valid, out_valid, sticky_tiny, sticky_ovf, lz, zero, TINY, OVF1 to 0.
REQ-035 in_ready = 1 during and after reset; in-flight transactions discarded on reset mid-operation.
REQ-036 First accept allowed on first rising edge after rst_n deasserts.

Verification
REQ-037 fr=0, er=0, db=0 -> 2 cycles later out_valid=1, lz=57, zero=1, TINY=0, OVF1=0.
REQ-038 db=1, fr=1<<56, er=1024 -> lz=0, OVF1=1, sticky_ovf=1 after handshake; er=1023 -> OVF1=0.
REQ-039 db=1, fr=1<<56, er=-1022 -> TINY=0; er=-1023 -> TINY=1, sticky_tiny=1.
REQ-040 db=0, fr=1<<50, er=-120 -> lz=6, en=-126, TINY=0; er=-121 -> TINY=1.
REQ-041 Issue 4 back-to-back operands with out_ready=0 for 6 cycles -> in_ready=0 once 2 held, outputs stable, all 4 delivered in order after release.
REQ-042 flag_clr with TINY handshake same cycle -> sticky_tiny=1; rst_n pulse with 2 in flight -> out_valid=0, stickies 0, no stale output after reset.
